// File: rtl/sweeper_pkg.sv
// Shared types and instruction-layout helpers for the DDS frequency sweeper.
// Instruction word, MSB first: {mode[1:0], num_steps, init_freq, dwell, freq_step}.
package sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DWELL = 2'd2
    } sweep_state_t;

    // Encoding 3 is reserved and decodes as MODE_UP.
    typedef enum logic [1:0] {
        MODE_UP   = 2'd0,
        MODE_DOWN = 2'd1,
        MODE_TRI  = 2'd2
    } sweep_mode_t;

    function automatic int unsigned instr_width(input int unsigned freq_w,
                                                input int unsigned dwell_w,
                                                input int unsigned steps_w);
        return 2 + steps_w + 2 * freq_w + dwell_w;
    endfunction

    function automatic int unsigned off_dwell(input int unsigned freq_w);
        return freq_w;
    endfunction

    function automatic int unsigned off_init(input int unsigned freq_w,
                                             input int unsigned dwell_w);
        return freq_w + dwell_w;
    endfunction

    function automatic int unsigned off_steps(input int unsigned freq_w,
                                              input int unsigned dwell_w);
        return 2 * freq_w + dwell_w;
    endfunction

    function automatic int unsigned off_mode(input int unsigned freq_w,
                                             input int unsigned dwell_w,
                                             input int unsigned steps_w);
        return 2 * freq_w + dwell_w + steps_w;
    endfunction

endpackage

// File: rtl/param_frequency_sweeper_if.sv
// FWFT instruction-FIFO read interface between the FIFO (master) and the sweeper (slave).
interface param_frequency_sweeper_if #(
    parameter int unsigned FREQ_W  = 32,
    parameter int unsigned DWELL_W = 16,
    parameter int unsigned STEPS_W = 16
);
    localparam int unsigned INSTR_W = sweeper_pkg::instr_width(FREQ_W, DWELL_W, STEPS_W);

    logic [INSTR_W-1:0] fifo_data;
    logic               fifo_empty;
    logic               fifo_rd_en;

    modport master (
        output fifo_data,
        output fifo_empty,
        input  fifo_rd_en
    );

    modport slave (
        input  fifo_data,
        input  fifo_empty,
        output fifo_rd_en
    );

endinterface

// File: rtl/sweep_step_gen.sv
// Dwell counter and step/direction sequencer: flags when a step's dwell expires and
// whether another step follows, and which direction the next step moves.
module sweep_step_gen
    import sweeper_pkg::*;
#(
    parameter int unsigned DWELL_W = 16,
    parameter int unsigned STEPS_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               run,
    input  logic               abort,
    input  logic [1:0]         mode,
    input  logic [STEPS_W-1:0] num_steps,
    input  logic [DWELL_W-1:0] dwell,
    output logic               advance,
    output logic               last,
    output logic               step_down,
    output logic [STEPS_W:0]   step_idx
);

    localparam logic [STEPS_W:0]   SONE = (STEPS_W + 1)'(1);
    localparam logic [DWELL_W-1:0] DONE = DWELL_W'(1);

    logic [DWELL_W-1:0] cnt_q, cnt_d, reload;
    logic [STEPS_W:0]   idx_q, idx_d;
    logic [STEPS_W:0]   n_eff, total, last_idx;
    logic               is_tri, expire;

    always_comb begin
        n_eff    = (num_steps == '0) ? SONE : {1'b0, num_steps};
        is_tri   = (mode == MODE_TRI);
        // Triangle shares the peak between the rising and falling legs.
        total    = is_tri ? ((n_eff << 1) - SONE) : n_eff;
        last_idx = total - SONE;
        reload   = (dwell == '0) ? '0 : (dwell - DONE);

        expire    = run && (cnt_q == '0);
        last      = expire && (idx_q == last_idx);
        advance   = expire && !abort && (idx_q != last_idx);
        step_down = (mode == MODE_DOWN) || (is_tri && (idx_q >= (n_eff - SONE)));

        cnt_d = cnt_q;
        idx_d = idx_q;
        if (load) begin
            cnt_d = reload;
            idx_d = '0;
        end else if (advance) begin
            cnt_d = reload;
            idx_d = idx_q + SONE;
        end else if (run && (cnt_q != '0)) begin
            cnt_d = cnt_q - DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign step_idx = idx_q;

endmodule

// File: rtl/param_frequency_sweeper.sv
// Instruction-driven DDS frequency sweeper: pops sweep instructions from an FWFT FIFO and
// steps the tuning word up, down or triangle. Optional SWEEP_LOOP_EN adds loop_en re-run.
module param_frequency_sweeper
    import sweeper_pkg::*;
#(
    parameter int unsigned FREQ_W  = 32,
    parameter int unsigned DWELL_W = 16,
    parameter int unsigned STEPS_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    param_frequency_sweeper_if.slave  fifo_if,
    input  logic                      abort,
`ifdef SWEEP_LOOP_EN
    input  logic                      loop_en,
`endif
    output logic [FREQ_W-1:0]         dds_freq,
    output logic                      step_strobe,
    output logic [STEPS_W:0]          step_index,
    output logic                      sweep_start,
    output logic                      sweep_done,
    output logic                      sweep_aborted,
    output logic                      busy
);

    localparam int unsigned INSTR_W   = instr_width(FREQ_W, DWELL_W, STEPS_W);
    localparam int unsigned OFF_DWELL = off_dwell(FREQ_W);
    localparam int unsigned OFF_INIT  = off_init(FREQ_W, DWELL_W);
    localparam int unsigned OFF_STEPS = off_steps(FREQ_W, DWELL_W);
    localparam int unsigned OFF_MODE  = off_mode(FREQ_W, DWELL_W, STEPS_W);

    sweep_state_t       state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [FREQ_W-1:0]  dds_freq_q, dds_freq_d;
    logic               step_strobe_q, step_strobe_d;
    logic               sweep_start_q, sweep_start_d;
    logic               sweep_done_q, sweep_done_d;
    logic               sweep_aborted_q, sweep_aborted_d;
    logic               busy_q, busy_d;

    logic               rd_en, loop_hit;
    logic               gen_load, gen_run, gen_advance, gen_last, gen_down;
    logic [STEPS_W:0]   gen_idx;

    logic [1:0]         f_mode;
    logic [STEPS_W-1:0] f_steps;
    logic [FREQ_W-1:0]  f_init, f_step;
    logic [DWELL_W-1:0] f_dwell;

    assign f_mode  = instr_q[OFF_MODE +: 2];
    assign f_steps = instr_q[OFF_STEPS +: STEPS_W];
    assign f_init  = instr_q[OFF_INIT +: FREQ_W];
    assign f_dwell = instr_q[OFF_DWELL +: DWELL_W];
    assign f_step  = instr_q[0 +: FREQ_W];

`ifdef SWEEP_LOOP_EN
    assign loop_hit = loop_en;
`else
    assign loop_hit = 1'b0;
`endif

    // Pop is combinational so an FWFT word is consumed only while it is actually present.
    assign rd_en    = (state_q == IDLE) && !fifo_if.fifo_empty && !reset;
    assign gen_load = (state_q == LOAD) && !abort;
    assign gen_run  = (state_q == DWELL);

    sweep_step_gen #(
        .DWELL_W (DWELL_W),
        .STEPS_W (STEPS_W)
    ) u_step_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (gen_load),
        .run       (gen_run),
        .abort     (abort),
        .mode      (f_mode),
        .num_steps (f_steps),
        .dwell     (f_dwell),
        .advance   (gen_advance),
        .last      (gen_last),
        .step_down (gen_down),
        .step_idx  (gen_idx)
    );

    always_comb begin
        state_d         = state_q;
        instr_d         = instr_q;
        dds_freq_d      = dds_freq_q;
        step_strobe_d   = 1'b0;
        sweep_start_d   = 1'b0;
        sweep_done_d    = 1'b0;
        sweep_aborted_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rd_en) begin
                    instr_d = fifo_if.fifo_data;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    sweep_done_d    = 1'b1;
                    sweep_aborted_d = 1'b1;
                    state_d         = IDLE;
                end else begin
                    dds_freq_d    = f_init;
                    step_strobe_d = 1'b1;
                    sweep_start_d = 1'b1;
                    state_d       = DWELL;
                end
            end
            DWELL: begin
                // Abort wins even against a final-step expiry in the same cycle.
                if (abort) begin
                    sweep_done_d    = 1'b1;
                    sweep_aborted_d = 1'b1;
                    state_d         = IDLE;
                end else if (gen_last) begin
                    if (loop_hit) begin
                        state_d = LOAD;
                    end else begin
                        sweep_done_d = 1'b1;
                        state_d      = IDLE;
                    end
                end else if (gen_advance) begin
                    dds_freq_d    = gen_down ? (dds_freq_q - f_step) : (dds_freq_q + f_step);
                    step_strobe_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            instr_q         <= '0;
            dds_freq_q      <= '0;
            step_strobe_q   <= 1'b0;
            sweep_start_q   <= 1'b0;
            sweep_done_q    <= 1'b0;
            sweep_aborted_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            instr_q         <= instr_d;
            dds_freq_q      <= dds_freq_d;
            step_strobe_q   <= step_strobe_d;
            sweep_start_q   <= sweep_start_d;
            sweep_done_q    <= sweep_done_d;
            sweep_aborted_q <= sweep_aborted_d;
            busy_q          <= busy_d;
        end
    end

    assign fifo_if.fifo_rd_en = rd_en;
    assign dds_freq           = dds_freq_q;
    assign step_strobe        = step_strobe_q;
    assign step_index         = gen_idx;
    assign sweep_start        = sweep_start_q;
    assign sweep_done         = sweep_done_q;
    assign sweep_aborted      = sweep_aborted_q;
    assign busy               = busy_q;

endmodule

// File: tb/tb_param_frequency_sweeper.sv
// Directed bench for param_frequency_sweeper: small FWFT FIFO model, negedge event log,
// hand-computed expectations.
module tb_param_frequency_sweeper;

    localparam int unsigned FREQ_W  = 32;
    localparam int unsigned DWELL_W = 16;
    localparam int unsigned STEPS_W = 16;
    localparam int unsigned INSTR_W = 2 + STEPS_W + 2 * FREQ_W + DWELL_W;

    logic               clk = 1'b0;
    logic               reset;
    logic               abort;
    logic [FREQ_W-1:0]  dds_freq;
    logic               step_strobe;
    logic [STEPS_W:0]   step_index;
    logic               sweep_start, sweep_done, sweep_aborted, busy;
`ifdef SWEEP_LOOP_EN
    logic               loop_en;
`endif

    param_frequency_sweeper_if #(
        .FREQ_W  (FREQ_W),
        .DWELL_W (DWELL_W),
        .STEPS_W (STEPS_W)
    ) fif ();

    param_frequency_sweeper #(
        .FREQ_W  (FREQ_W),
        .DWELL_W (DWELL_W),
        .STEPS_W (STEPS_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fifo_if       (fif),
        .abort         (abort),
`ifdef SWEEP_LOOP_EN
        .loop_en       (loop_en),
`endif
        .dds_freq      (dds_freq),
        .step_strobe   (step_strobe),
        .step_index    (step_index),
        .sweep_start   (sweep_start),
        .sweep_done    (sweep_done),
        .sweep_aborted (sweep_aborted),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // FWFT FIFO model: the initial block owns wr_ptr/prog, the posedge process owns rd_ptr.
    logic [INSTR_W-1:0] prog [16];
    logic [3:0]         wr_ptr = '0;
    logic [3:0]         rd_ptr = '0;
    assign fif.fifo_empty = (rd_ptr == wr_ptr);
    assign fif.fifo_data  = prog[rd_ptr];

    int cyc = 0, rd_cnt = 0, rd_viol = 0, rd_cyc_last = 0, n_abort = 0;
    int n_cmp = 0, n_bad = 0;
    logic [FREQ_W-1:0] s_freq[$];
    int                s_cyc[$];
    int                st_cyc[$];
    int                dn_cyc[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fif.fifo_rd_en) begin
            if (fif.fifo_empty) begin
                rd_viol <= rd_viol + 1;
            end else begin
                rd_cnt      <= rd_cnt + 1;
                rd_ptr      <= rd_ptr + 4'd1;
                rd_cyc_last <= cyc;
            end
        end
    end

    always @(negedge clk) begin
        if (step_strobe) begin
            s_freq.push_back(dds_freq);
            s_cyc.push_back(cyc);
        end
        if (sweep_start)   st_cyc.push_back(cyc);
        if (sweep_done)    dn_cyc.push_back(cyc);
        if (sweep_aborted) n_abort = n_abort + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [INSTR_W-1:0] w);
        prog[wr_ptr] = w;
        wr_ptr       = wr_ptr + 4'd1;
    endtask

    task automatic wait_done(input int max, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            step();
            if (sweep_done) seen = 1'b1;
        end
    endtask

    task automatic wait_step(input int max, input int idx, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            step();
            if (step_strobe && step_index == (STEPS_W + 1)'(idx)) seen = 1'b1;
        end
    endtask

    function automatic logic [INSTR_W-1:0] mk(input logic [1:0] m, input logic [15:0] n,
                                              input logic [31:0] init, input logic [15:0] dw,
                                              input logic [31:0] st);
        return {m, n, init, dw, st};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        int b, bs, bd, br, ba;
        logic [31:0] tri_exp [5];
        tri_exp = '{32'h1000, 32'h1010, 32'h1020, 32'h1010, 32'h1000};

        reset = 1'b1;
        abort = 1'b0;
`ifdef SWEEP_LOOP_EN
        loop_en = 1'b0;
`endif
        repeat (3) step();
        check_eq("rst_dds_freq", dds_freq, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_step_index", step_index, 0);
        check_eq("rst_done", sweep_done, 0);
        check_eq("rst_rd_en", fif.fifo_rd_en, 0);
        reset = 1'b0;
        step();

        // Up sweep: 4 steps, 3 cycles each.
        b = s_freq.size(); bs = st_cyc.size(); bd = dn_cyc.size();
        push(mk(2'd0, 16'd4, 32'h0100_0000, 16'd3, 32'h0001_0000));
        wait_done(80, seen);
        check_eq("up_done_seen", seen, 1);
        check_eq("up_strobes", s_freq.size() - b, 4);
        for (int i = 0; i < 4; i++)
            check_eq("up_freq", s_freq[b+i], 32'h0100_0000 + i * 32'h0001_0000);
        check_eq("up_hold_0", s_cyc[b+1] - s_cyc[b], 3);
        check_eq("up_hold_2", s_cyc[b+3] - s_cyc[b+2], 3);
        check_eq("up_start_to_done", dn_cyc[bd] - st_cyc[bs], 12);
        check_eq("up_rd_to_start", st_cyc[bs] - rd_cyc_last, 2);
        check_eq("up_freq_hold", dds_freq, 32'h0103_0000);
        check_eq("up_last_index", step_index, 3);
        check_eq("up_busy_low", busy, 0);

        // Triangle: 2N-1 steps, peak applied once.
        b = s_freq.size(); bd = dn_cyc.size();
        push(mk(2'd2, 16'd3, 32'h0000_1000, 16'd1, 32'h0000_0010));
        wait_done(40, seen);
        check_eq("tri_done_seen", seen, 1);
        check_eq("tri_strobes", s_freq.size() - b, 5);
        for (int i = 0; i < 5; i++) check_eq("tri_freq", s_freq[b+i], tri_exp[i]);
        check_eq("tri_last_index", step_index, 4);
        check_eq("tri_done_lag", dn_cyc[bd] - s_cyc[b+4], 1);

        // Down sweep wrapping below zero.
        b = s_freq.size(); ba = n_abort;
        push(mk(2'd1, 16'd2, 32'h0000_0008, 16'd2, 32'h0000_0010));
        wait_done(40, seen);
        check_eq("down_done_seen", seen, 1);
        check_eq("down_strobes", s_freq.size() - b, 2);
        check_eq("down_wrap", s_freq[b+1], 32'hFFFF_FFF8);
        check_eq("down_not_aborted", n_abort - ba, 0);

        // Abort on the 2nd cycle of step index 1 with another instruction queued.
        ba = n_abort;
        push(mk(2'd0, 16'd10, 32'h0, 16'd4, 32'h1));
        push(mk(2'd0, 16'd1, 32'h0000_ABCD, 16'd1, 32'h0));
        wait_step(40, 1, seen);
        check_eq("abort_reach_step1", seen, 1);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("abort_done", sweep_done, 1);
        check_eq("abort_flag", sweep_aborted, 1);
        check_eq("abort_freq_hold", dds_freq, 32'h1);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_next_pop", fif.fifo_rd_en, 1);
        wait_done(20, seen);
        check_eq("abort_next_done", seen, 1);
        check_eq("abort_next_freq", dds_freq, 32'h0000_ABCD);
        check_eq("abort_count", n_abort - ba, 1);

        // Two queued N=0, dwell=0 instructions.
        br = rd_cnt; b = s_freq.size(); bd = dn_cyc.size(); bs = st_cyc.size();
        push(mk(2'd0, 16'd0, 32'h11, 16'd0, 32'h5));
        push(mk(2'd0, 16'd0, 32'h22, 16'd0, 32'h5));
        wait_done(20, seen);
        check_eq("zero_done1", seen, 1);
        wait_done(20, seen);
        check_eq("zero_done2", seen, 1);
        repeat (5) step();
        check_eq("zero_rd_count", rd_cnt - br, 2);
        check_eq("zero_strobes", s_freq.size() - b, 2);
        check_eq("zero_freq1", s_freq[b], 32'h11);
        check_eq("zero_freq2", s_freq[b+1], 32'h22);
        check_eq("zero_gap", st_cyc[bs+1] - dn_cyc[bd], 2);
        check_eq("zero_len", dn_cyc[bd] - st_cyc[bs], 1);

        // Abort held in IDLE must not block the pop.
        ba = n_abort;
        abort = 1'b1;
        push(mk(2'd0, 16'd1, 32'h55, 16'd1, 32'h0));
        step();
        abort = 1'b0;
        check_eq("idle_abort_popped", busy, 1);
        wait_done(20, seen);
        check_eq("idle_abort_done", seen, 1);
        check_eq("idle_abort_ignored", n_abort - ba, 0);
        check_eq("idle_abort_freq", dds_freq, 32'h55);

        // Reset mid-DWELL.
        bd = dn_cyc.size();
        push(mk(2'd0, 16'd5, 32'h77, 16'd5, 32'h1));
        wait_step(40, 1, seen);
        check_eq("rst_reach_step1", seen, 1);
        step();
        reset = 1'b1;
        step();
        check_eq("midrst_dds", dds_freq, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_index", step_index, 0);
        check_eq("midrst_strobe", step_strobe, 0);
        check_eq("midrst_done", sweep_done, 0);
        reset = 1'b0;
        repeat (8) step();
        check_eq("midrst_no_done", dn_cyc.size() - bd, 0);
        check_eq("midrst_idle", busy, 0);

`ifdef SWEEP_LOOP_EN
        // Looping: three starts without a done, then normal exit.
        bs = st_cyc.size(); bd = dn_cyc.size(); ba = n_abort;
        loop_en = 1'b1;
        push(mk(2'd0, 16'd2, 32'h100, 16'd1, 32'h1));
        for (int i = 0; i < 60 && (st_cyc.size() - bs) < 3; i++) step();
        check_eq("loop_starts", st_cyc.size() - bs, 3);
        check_eq("loop_no_done", dn_cyc.size() - bd, 0);
        loop_en = 1'b0;
        wait_done(20, seen);
        check_eq("loop_exit_done", seen, 1);
        check_eq("loop_not_aborted", n_abort - ba, 0);
`endif

        check_eq("rd_never_empty", rd_viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
